// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with start-bit validation, stop-bit check and optional even parity.
// Define UART_RX_PARITY_EN to add an even parity bit between the data bits and the stop bit.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a low sample on a tick
// S_START  | start edge seen, confirm the line is still low at mid start bit
// S_DATA   | sample WIDTH data bits at mid-bit, LSB first
// S_PARITY | sample the even parity bit (UART_RX_PARITY_EN only)
// S_STOP   | sample the stop bit, commit the frame, return to idle
module uart_rx_os #(
    parameter int WIDTH      = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      wait_clock,
    input  logic             rx_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             parity_bit_err,
    output logic             stop_bit_err,
    output logic             busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            state_q, state_nxt;
    logic [1:0]        sync_q;
    logic              line;
    logic [15:0]       tick_cnt;
    logic              tick;
    logic [SW-1:0]     samp_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [WIDTH-1:0]  shift_q;
    logic              sample;
    logic              shift_en;
    logic              commit;
    logic              par_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx_in};
    end
    assign line = sync_q[1];

    // >= rather than == so a divisor lowered below the running count cannot stall the tick
    assign tick = (tick_cnt >= wait_clock);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 16'd1;
    end

    assign sample = tick && (state_q != S_IDLE) &&
                    (samp_cnt == ((state_q == S_START) ? HALF_LAST : BIT_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:   if (tick && !line) state_nxt = S_START;
            S_START:  if (sample) state_nxt = line ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (sample && bit_cnt == DATA_LAST) state_nxt = S_PARITY;
            S_PARITY: if (sample) state_nxt = S_STOP;
`else
            S_DATA:   if (sample && bit_cnt == DATA_LAST) state_nxt = S_STOP;
`endif
            S_STOP:   if (sample) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            S_DATA:  shift_en = sample;
            S_STOP:  commit   = sample;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            samp_cnt <= '0;
        else if (state_nxt != state_q || sample || state_q == S_IDLE)
            samp_cnt <= '0;
        else if (tick)
            samp_cnt <= samp_cnt + SW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   bit_cnt <= '0;
        else if (state_q != S_DATA) bit_cnt <= '0;
        else if (shift_en)         bit_cnt <= bit_cnt + BW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           shift_q <= '0;
        else if (shift_en) shift_q <= {line, shift_q[WIDTH-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    logic par_mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_mis_q <= 1'b0;
        else if (state_q == S_PARITY && sample)
            par_mis_q <= line ^ (^shift_q);
    end
    assign par_mis = par_mis_q;
`else
    assign par_mis = 1'b0;
`endif

    // Data is delivered even when a flag is set; the flags qualify it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out       <= '0;
            data_valid     <= 1'b0;
            parity_bit_err <= 1'b0;
            stop_bit_err   <= 1'b0;
        end else begin
            data_valid <= commit;
            if (commit) begin
                data_out       <= shift_q;
                parity_bit_err <= par_mis;
                stop_bit_err   <= ~line;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: table vectors, hand-written corner sequences and randomized frames
// checked against a frame-level reference model. Follows UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_os;

    localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] wait_clock;
    logic        rx_in;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        parity_bit_err;
    logic        stop_bit_err;
    logic        busy;

    uart_rx_os #(.WIDTH(8), .OVERSAMPLE(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .wait_clock     (wait_clock),
        .rx_in          (rx_in),
        .data_out       (data_out),
        .data_valid     (data_valid),
        .parity_bit_err (parity_bit_err),
        .stop_bit_err   (stop_bit_err),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } frame_t;

    typedef struct packed {
        logic [7:0] data;
        logic       par_flip;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     wide_cnt = 0;
    logic   dv_prev = 1'b0;
    frame_t got_q[$];

    always @(negedge clk) begin
        frame_t f;
        if (data_valid) begin
            f = {data_out, parity_bit_err, stop_bit_err};
            got_q.push_back(f);
            if (dv_prev) wide_cnt++;
        end
        dv_prev = data_valid;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: what a correct receiver reports for a frame as sent on the wire.
    function automatic frame_t model(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        frame_t m;
        m.data = d;
        m.perr = PAR_EN && (par_bit != (^d));
        m.serr = !stop_bit;
        return m;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                              input int gap_bits, output logic busy_ok);
        logic bits_q[$];
        busy_ok = 1'b1;
        bits_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits_q.push_back(d[i]);
        if (PAR_EN) bits_q.push_back(par_bit);
        bits_q.push_back(stop_bit);
        foreach (bits_q[i]) begin
            rx_in = bits_q[i];
            repeat (20) @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            repeat (BIT_CLK - 20) @(negedge clk);
        end
        rx_in = 1'b1;
        repeat (gap_bits * BIT_CLK) @(negedge clk);
    endtask

    task automatic expect_frame(input string nm, input frame_t exp);
        frame_t g;
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no data_valid pulse, expected data %02h", nm, exp.data);
        end else begin
            g = got_q.pop_front();
            chk({nm, ".data"}, 32'(g.data), 32'(exp.data));
            chk({nm, ".perr"}, 32'(g.perr), 32'(exp.perr));
            chk({nm, ".serr"}, 32'(g.serr), 32'(exp.serr));
        end
    endtask

    initial begin
        vec_t   vecs[4];
        frame_t e;
        logic   bok;
        logic [7:0] d;
        logic   pf, sb;

        vecs[0] = '{data: 8'hA5, par_flip: 1'b0, stop_bit: 1'b1, exp_data: 8'hA5, exp_perr: 1'b0,   exp_serr: 1'b0};
        vecs[1] = '{data: 8'h3C, par_flip: 1'b1, stop_bit: 1'b1, exp_data: 8'h3C, exp_perr: PAR_EN, exp_serr: 1'b0};
        vecs[2] = '{data: 8'h00, par_flip: 1'b0, stop_bit: 1'b0, exp_data: 8'h00, exp_perr: 1'b0,   exp_serr: 1'b1};
        vecs[3] = '{data: 8'h81, par_flip: 1'b0, stop_bit: 1'b1, exp_data: 8'h81, exp_perr: 1'b0,   exp_serr: 1'b0};

        rst        = 1'b1;
        rx_in      = 1'b1;
        wait_clock = 16'd3;
        repeat (5) @(negedge clk);
        chk("reset.data_out", 32'(data_out), 32'h0);
        chk("reset.data_valid", 32'(data_valid), 32'h0);
        chk("reset.perr", 32'(parity_bit_err), 32'h0);
        chk("reset.serr", 32'(stop_bit_err), 32'h0);
        chk("reset.busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        chk("idle.busy", 32'(busy), 32'h0);

        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i].data, (^vecs[i].data) ^ vecs[i].par_flip, vecs[i].stop_bit, 2, bok);
            e = {vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_serr};
            expect_frame($sformatf("vec%0d", i), e);
            chk($sformatf("vec%0d.single_pulse", i), 32'(got_q.size()), 32'h0);
            if (i == 0) chk("vec0.busy_during_frame", 32'(bok), 32'h1);
        end

        // Short low glitch: start detected, then rejected at mid start bit.
        rx_in = 1'b0;
        repeat (20) @(negedge clk);
        rx_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch.busy_seen", 32'(busy), 32'h1);
        repeat (60) @(negedge clk);
        chk("glitch.busy_clear", 32'(busy), 32'h0);
        chk("glitch.no_valid", 32'(got_q.size()), 32'h0);
        chk("glitch.data_held", 32'(data_out), 32'h81);

        send_frame(8'h12, ^8'h12, 1'b1, 0, bok);
        send_frame(8'h34, ^8'h34, 1'b1, 2, bok);
        expect_frame("b2b0", model(8'h12, ^8'h12, 1'b1));
        expect_frame("b2b1", model(8'h34, ^8'h34, 1'b1));
        chk("b2b.count", 32'(got_q.size()), 32'h0);

        // Reset in the middle of data bit 3 of 0xFF.
        rx_in = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * BIT_CLK + 32) @(negedge clk);
        chk("rstmid.busy_before", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstmid.data_out", 32'(data_out), 32'h0);
        chk("rstmid.data_valid", 32'(data_valid), 32'h0);
        chk("rstmid.flags", 32'({parity_bit_err, stop_bit_err}), 32'h0);
        chk("rstmid.busy", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3 * BIT_CLK) @(negedge clk);
        chk("rstmid.no_valid", 32'(got_q.size()), 32'h0);
        chk("rstmid.busy_after", 32'(busy), 32'h0);
        send_frame(8'h5A, ^8'h5A, 1'b1, 2, bok);
        expect_frame("after_rst", model(8'h5A, ^8'h5A, 1'b1));

        for (int n = 0; n < 16; n++) begin
            d  = 8'($urandom_range(0, 255));
            pf = ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 3) != 0);
            send_frame(d, (^d) ^ pf, sb, 2, bok);
            expect_frame($sformatf("rand%0d", n), model(d, (^d) ^ pf, sb));
        end
        chk("rand.no_extra", 32'(got_q.size()), 32'h0);
        chk("data_valid.width", 32'(wide_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Standalone oversampling UART receiver: the far-end receiver of the serial link driven by the team's UART transmitter. It recovers framed serial data from an asynchronous line and checks parity and stop bits. It derives its own sample tick from the system clock and sits next to the baud generator / TX pair in systems where the line crosses between boards or clock domains. Each received word is presented with a one-cycle valid pulse and per-frame error flags.

## Interface
- WIDTH, 8, data bits per frame.
- OVERSAMPLE, 16, sample ticks per bit period; even, ≥4.
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-high.
- wait_clock  input  16  tick divisor; one sample tick every wait_clock+1 clk cycles.
- rx_in  input  1  serial line, asynchronous to clk, idle high.
- data_out  output  WIDTH  last received word; held until the next frame completes.
- data_valid  output  1  one-cycle pulse when data_out updates.
- parity_bit_err  output  1  parity mismatch on last frame; held until the next frame completes.
- stop_bit_err  output  1  stop bit sampled low on last frame; held until the next frame completes.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- rx_in passes through a 2-flop synchronizer. All decisions use the synchronized value.
- Tick counter: free-running 0..wait_clock. It asserts tick when count == wait_clock, then wraps to 0. With wait_clock = 0, tick is asserted every clk.
- Sample counter: counts ticks within a bit. It is cleared on every state change and after every sample.
- FSM states and transitions:
  - IDLE: on a tick with line = 0, go to START.
  - START: on the tick where the sample counter = OVERSAMPLE/2−1, check the line. If the line is still 0, go to DATA. Otherwise it is a false start; go to IDLE with no outputs changed.
  - DATA: on the tick where the sample counter = OVERSAMPLE−1 (mid-bit), shift in the line, LSB first. After WIDTH bits, go to PARITY, or to STOP if parity is compiled out.
  - PARITY: mid-bit sample. Expected value is even parity (XOR of the data bits).
  - STOP: mid-bit sample, then go straight to IDLE. There is no wait for the end of the stop bit, so an immediately following start edge is caught.
- Frame commit (in the STOP sample cycle):
  - data_out <= shift register.
  - parity_bit_err <= mismatch.
  - stop_bit_err <= ~line.
  - data_valid pulses.
  - Data is delivered even when an error flag is set.
- Reset values: data_out = 0, data_valid = 0, parity_bit_err = 0, stop_bit_err = 0, busy = 0, FSM = IDLE, all counters and synchronizer flops = 0, except the synchronizer, which resets to 1 (idle line).

## Timing
- Line to FSM: 2 clk of synchronizer delay plus up to wait_clock+1 clk of tick quantization.
- data_valid, data_out and the error flags are registered. They update on the clk edge following the tick that samples the stop bit. data_valid is high for exactly 1 clk.
- busy rises the clk after start detection. It falls in the same clk in which data_valid rises, or after a false start.
- Frame length, start detect to data_valid: (WIDTH+1+P)·OVERSAMPLE + OVERSAMPLE/2 ticks, with P = 1 when parity is enabled.
- Changing wait_clock while busy is not supported. The framing of the current frame is undefined; recovery occurs on the next IDLE.
- rst asserted mid-frame: all state clears immediately, no data_valid is generated, and reception resumes on the next low line after release.
- A low glitch shorter than OVERSAMPLE/2−1 ticks is rejected as a false start.

## Configuration
- UART_RX_PARITY_EN defined: the frame is start, WIDTH data, even parity, stop. The PARITY state is present and parity_bit_err is live.
- UART_RX_PARITY_EN undefined: the frame is start, WIDTH data, stop. The PARITY state is removed and parity_bit_err is tied 0.

## Test plan
Common setup for all cases: WIDTH = 8, OVERSAMPLE = 16, wait_clock = 3 (64 clk per bit), parity enabled.
- Clean frame: send 0xA5, parity 0, stop 1. Expect one data_valid pulse, data_out = 0xA5, both error flags 0, and busy high throughout the frame.
- Glitch: hold rx_in low for 20 clk (5 ticks), then high. Expect no data_valid, busy returns to 0, and data_out is unchanged.
- Parity error: send 0x3C with parity 1. Expect data_out = 0x3C, parity_bit_err = 1, stop_bit_err = 0.
- Stop error: send 0x00, parity 0, stop 0. Expect data_out = 0x00 and stop_bit_err = 1. Then send 0x81 correctly and expect both flags to clear.
- Back-to-back: send 0x12 then 0x34 with no idle gap between the stop bit and the next start bit. Expect two data_valid pulses with data_out = 0x12, then 0x34.
- Reset mid-frame: assert rst during data bit 3 of 0xFF. Expect all outputs 0 immediately and no data_valid. Then send 0x5A and expect it to be received correctly.
